processors_core: RTL and testbench



---
 rtl/processors_pkg.sv | 76 +++++++
 rtl/processors_lane.sv | 40 ++++
 rtl/processors_core.sv | 238 +++++++++++++++++++++++
 tb/tb_processors_core.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processors_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : processors_pkg                                               |
// | Description : Shared constants, FSM state and region encodings, and the    |
// |               switch-to-level decode helpers for the alpha-compositing     |
// |               engine.                                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package processors_pkg;

  localparam int IMG_W  = 200;
  localparam int IMG_H  = 200;
  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int N_VEC  = 10000;

  // Counter limits in the counters' own 8-bit width.
  localparam logic [7:0] X_LAST   = 8'(IMG_W - LANES);
  localparam logic [7:0] Y_LAST   = 8'(IMG_H - 1);
  localparam logic [7:0] X_STEP   = 8'(LANES);
  localparam logic [7:0] HALF_IMG = 8'd100;

  // Foreground channel levels.
  localparam logic [7:0] FG_L0   = 8'd0;
  localparam logic [7:0] FG_L25  = 8'd64;
  localparam logic [7:0] FG_L75  = 8'd191;
  localparam logic [7:0] FG_L100 = 8'd255;

  // Foreground weight in Q8 (256 == fully opaque foreground).
  localparam logic [8:0] A_TD0   = 9'd256;
  localparam logic [8:0] A_TD25  = 9'd192;
  localparam logic [8:0] A_TD75  = 9'd64;
  localparam logic [8:0] A_TD100 = 9'd0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MARK   = 3'd1,
    ST_EMIT_R = 3'd2,
    ST_EMIT_G = 3'd3,
    ST_EMIT_B = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    RG_NONE = 3'd0,
    RG_H    = 3'd1,
    RG_V    = 3'd2,
    RG_D    = 3'd3,
    RG_P    = 3'd4
  } region_e;

  // Later assignments win, giving priority 100 > 75 > 25 > 0.
  // The 0 % switch selects the same value as "nothing set".
  function automatic logic [7:0] fg_level(input logic s25, input logic s75,
                                          input logic s100);
    logic [7:0] lvl;
    lvl = FG_L0;
    if (s25)  lvl = FG_L25;
    if (s75)  lvl = FG_L75;
    if (s100) lvl = FG_L100;
    return lvl;
  endfunction

  // Priority TD100 > TD75 > TD25 > TD0; TD0 equals "nothing set".
  function automatic logic [8:0] alpha_level(input logic td25, input logic td75,
                                             input logic td100);
    logic [8:0] a;
    a = A_TD0;
    if (td25)  a = A_TD25;
    if (td75)  a = A_TD75;
    if (td100) a = A_TD100;
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/processors_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : processors_lane                                              |
// | Description : Combinational single-lane alpha blend.                       |
// |               out = (a*F + (256-a)*B) >> 8 inside the mask, else B.        |
// | Ports       : fg_i    - foreground level (8b)                              |
// |               bg_i    - background value (8b)                              |
// |               alpha_i - foreground weight, Q8 (9b, 0..256)                 |
// |               inside_i- pixel lies inside the composite region             |
// |               lane_o  - 32-bit lane, value in [7:0], upper bits zero       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module processors_lane
  import processors_pkg::*;
(
  input  logic [7:0]        fg_i,
  input  logic [7:0]        bg_i,
  input  logic [8:0]        alpha_i,
  input  logic              inside_i,
  output logic [LANE_W-1:0] lane_o
);

  logic [8:0]  w_beta;
  logic [16:0] w_fg_term;
  logic [16:0] w_bg_term;
  logic [16:0] w_sum;

  assign w_beta    = 9'd256 - alpha_i;
  assign w_fg_term = 17'(alpha_i) * 17'(fg_i);
  assign w_bg_term = 17'(w_beta) * 17'(bg_i);
  // Weights sum to 256, so w_sum <= 256*255 and the shifted result fits 8 bits.
  assign w_sum     = w_fg_term + w_bg_term;

  always_comb begin
    lane_o = LANE_W'(bg_i);
    if (inside_i) lane_o = LANE_W'(w_sum >> 8);
  end

endmodule
`default_nettype wire

// File: rtl/processors_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : processors_core                                              |
// | Description : Vector alpha-compositing engine. Composes a switch-selected  |
// |               solid colour over a generated 200x200 background and streams |
// |               4-pixel vectors out one colour plane per cycle.              |
// | Ports       : clk, rst (sync, active-high)                                 |
// |               swInicio             - start request (level)                 |
// |               swIn{R,G,B}{0,25,75,100} - foreground level selects          |
// |               swTD{0,25,75,100}    - transparency degree                   |
// |               swH/swV/swD/swP      - composite region                      |
// |               GPIO[127:0]          - four 32-bit lanes, pixel x0+k in k    |
// |               GPIOEnR/G/B          - plane strobe for GPIO                  |
// |               GPIOEn               - one-cycle frame-start marker           |
// | Config      : PROCESSORS_MASK_EN - honour region switches; when undefined  |
// |               every pixel is composited and swH/swV/swD/swP are ignored.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module processors_core
  import processors_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    swInicio,
  input  logic                    swInR0,
  input  logic                    swInR25,
  input  logic                    swInR75,
  input  logic                    swInR100,
  input  logic                    swInG0,
  input  logic                    swInG25,
  input  logic                    swInG75,
  input  logic                    swInG100,
  input  logic                    swInB0,
  input  logic                    swInB25,
  input  logic                    swInB75,
  input  logic                    swInB100,
  input  logic                    swTD0,
  input  logic                    swTD25,
  input  logic                    swTD75,
  input  logic                    swTD100,
  input  logic                    swH,
  input  logic                    swV,
  input  logic                    swD,
  input  logic                    swP,
  output logic [LANES*LANE_W-1:0] GPIO,
  output logic                    GPIOEnR,
  output logic                    GPIOEnG,
  output logic                    GPIOEnB,
  output logic                    GPIOEn
);

  // The 0 % / TD0 selects decode to the same value as "no switch set".
  logic w_unused_sel0;
  assign w_unused_sel0 = ^{swInR0, swInG0, swInB0, swTD0};

  state_e     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic       armed_q, armed_d;
  logic [7:0] fg_r_q, fg_g_q, fg_b_q;
  logic [8:0] alpha_q;
  logic [LANES*LANE_W-1:0] gpio_q;
  logic       en_r_q, en_g_q, en_b_q, gpioen_q;

  logic       w_start;
  logic       w_last;
  logic       w_emit;
  logic [7:0] w_fg;
  logic [LANES*LANE_W-1:0] w_vec;

  // armed_q requires swInicio to be seen low before a start is accepted,
  // so a start level held through reset or DONE cannot relaunch a frame.
  assign w_start = (state_q == ST_IDLE) && swInicio && armed_q;
  assign w_last  = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    armed_d = armed_q;
    if (!swInicio)    armed_d = 1'b1;
    else if (w_start) armed_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        x_d = '0;
        y_d = '0;
        if (w_start) state_d = ST_MARK;
      end
      ST_MARK: begin
        x_d     = '0;
        y_d     = '0;
        state_d = ST_EMIT_R;
      end
      ST_EMIT_R: state_d = ST_EMIT_G;
      ST_EMIT_G: state_d = ST_EMIT_B;
      ST_EMIT_B: begin
        if (w_last) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_EMIT_R;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 8'd1;
          end else begin
            x_d = x_q + X_STEP;
          end
        end
      end
      ST_DONE: if (!swInicio) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      armed_q <= armed_d;
    end
  end

  // Switch latch: captured once per run on the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      fg_r_q  <= '0;
      fg_g_q  <= '0;
      fg_b_q  <= '0;
      alpha_q <= A_TD0;
    end else if (w_start) begin
      fg_r_q  <= fg_level(swInR25, swInR75, swInR100);
      fg_g_q  <= fg_level(swInG25, swInG75, swInG100);
      fg_b_q  <= fg_level(swInB25, swInB75, swInB100);
      alpha_q <= alpha_level(swTD25, swTD75, swTD100);
    end
  end

`ifdef PROCESSORS_MASK_EN
  region_e region_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      region_q <= RG_NONE;
    end else if (w_start) begin
      if (swP)      region_q <= RG_P;
      else if (swD) region_q <= RG_D;
      else if (swV) region_q <= RG_V;
      else if (swH) region_q <= RG_H;
      else          region_q <= RG_NONE;
    end
  end
`else
  logic w_unused_region;
  assign w_unused_region = ^{swH, swV, swD, swP};
`endif

  // Output data is computed for the plane/vector about to be presented
  // (next-state view) so data and strobe register on the same edge.
  assign w_emit = (state_d == ST_EMIT_R) || (state_d == ST_EMIT_G) ||
                  (state_d == ST_EMIT_B);

  always_comb begin
    case (state_d)
      ST_EMIT_G: w_fg = fg_g_q;
      ST_EMIT_B: w_fg = fg_b_q;
      default:   w_fg = fg_r_q;
    endcase
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0] w_px;
    logic [8:0] w_xy_sum;
    logic [7:0] w_bg;
    logic       w_inside;

    assign w_px     = x_d + 8'(k);
    assign w_xy_sum = {1'b0, w_px} + {1'b0, y_d};

    always_comb begin
      case (state_d)
        ST_EMIT_G: w_bg = y_d;
        ST_EMIT_B: w_bg = 8'(w_xy_sum >> 1);
        default:   w_bg = w_px;
      endcase
    end

`ifdef PROCESSORS_MASK_EN
    always_comb begin
      case (region_q)
        RG_P:    w_inside = 1'b1;
        RG_D:    w_inside = (w_px >= y_d);
        RG_V:    w_inside = (w_px < HALF_IMG);
        RG_H:    w_inside = (y_d < HALF_IMG);
        default: w_inside = 1'b0;
      endcase
    end
`else
    assign w_inside = 1'b1;
`endif

    processors_lane u_lane (
      .fg_i     (w_fg),
      .bg_i     (w_bg),
      .alpha_i  (alpha_q),
      .inside_i (w_inside),
      .lane_o   (w_vec[k*LANE_W +: LANE_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q   <= '0;
      en_r_q   <= 1'b0;
      en_g_q   <= 1'b0;
      en_b_q   <= 1'b0;
      gpioen_q <= 1'b0;
    end else begin
      gpioen_q <= (state_d == ST_MARK);
      en_r_q   <= (state_d == ST_EMIT_R);
      en_g_q   <= (state_d == ST_EMIT_G);
      en_b_q   <= (state_d == ST_EMIT_B);
      if (w_emit) gpio_q <= w_vec;
    end
  end

  assign GPIO    = gpio_q;
  assign GPIOEnR = en_r_q;
  assign GPIOEnG = en_g_q;
  assign GPIOEnB = en_b_q;
  assign GPIOEn  = gpioen_q;

endmodule
`default_nettype wire

// File: tb/tb_processors_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_processors_core                                           |
// | Description : Self-checking bench for processors_core against a           |
// |               pixel-level reference model of the compositing rules.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_processors_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic swInicio = 1'b0;
  // Switch groups indexed [0]=0%, [1]=25%, [2]=75%, [3]=100%.
  logic [3:0] sw_r = '0, sw_g = '0, sw_b = '0, sw_td = '0;
  // Region switches [0]=H, [1]=V, [2]=D, [3]=P.
  logic [3:0] sw_reg = '0;

  logic [127:0] GPIO;
  logic GPIOEnR, GPIOEnG, GPIOEnB, GPIOEn;
  logic [3:0] stb;
  assign stb = {GPIOEn, GPIOEnR, GPIOEnG, GPIOEnB};

  // Configuration captured by the model at each start.
  logic [3:0] m_r, m_g, m_b, m_td, m_reg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  processors_core dut (
    .clk      (clk),
    .rst      (rst),
    .swInicio (swInicio),
    .swInR0   (sw_r[0]),  .swInR25 (sw_r[1]),  .swInR75 (sw_r[2]),  .swInR100 (sw_r[3]),
    .swInG0   (sw_g[0]),  .swInG25 (sw_g[1]),  .swInG75 (sw_g[2]),  .swInG100 (sw_g[3]),
    .swInB0   (sw_b[0]),  .swInB25 (sw_b[1]),  .swInB75 (sw_b[2]),  .swInB100 (sw_b[3]),
    .swTD0    (sw_td[0]), .swTD25  (sw_td[1]), .swTD75  (sw_td[2]), .swTD100  (sw_td[3]),
    .swH      (sw_reg[0]), .swV    (sw_reg[1]), .swD    (sw_reg[2]), .swP      (sw_reg[3]),
    .GPIO     (GPIO),
    .GPIOEnR  (GPIOEnR),
    .GPIOEnG  (GPIOEnG),
    .GPIOEnB  (GPIOEnB),
    .GPIOEn   (GPIOEn)
  );

  // ---------------- reference model ----------------
  function automatic int fg_of(input logic [3:0] s);
    if (s[3]) return 255;
    if (s[2]) return 191;
    if (s[1]) return 64;
    return 0;
  endfunction

  function automatic int alpha_of(input logic [3:0] s);
    if (s[3]) return 0;
    if (s[2]) return 64;
    if (s[1]) return 192;
    return 256;
  endfunction

  function automatic bit inside_of(input int x, input int y, input logic [3:0] rg);
`ifdef PROCESSORS_MASK_EN
    if (rg[3]) return 1'b1;
    if (rg[2]) return x >= y;
    if (rg[1]) return x < 100;
    if (rg[0]) return y < 100;
    return 1'b0;
`else
    return (x >= 0) || (y >= 0) || (rg != 4'hx);
`endif
  endfunction

  // Expected 128-bit vector for vector index v, plane 0=R 1=G 2=B.
  function automatic logic [127:0] exp_vec(input int v, input int plane);
    logic [127:0] r;
    int x, y, bg, f, a, val;
    r = '0;
    a = alpha_of(m_td);
    for (int k = 0; k < 4; k++) begin
      x = (v % 50) * 4 + k;
      y = v / 50;
      case (plane)
        0:       begin bg = x;           f = fg_of(m_r); end
        1:       begin bg = y;           f = fg_of(m_g); end
        default: begin bg = (x + y) / 2; f = fg_of(m_b); end
      endcase
      if (inside_of(x, y, m_reg)) val = (a * f + (256 - a) * bg) / 256;
      else                        val = bg;
      r[32*k +: 32] = 32'(val);
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_stb(input int plane);
    return 4'b0100 >> plane;
  endfunction

  // ---------------- stimulus helpers (no checks) ----------------
  task automatic do_reset();
    rst = 1'b1;
    swInicio = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_sw();
    sw_r   = 4'($urandom_range(0, 15));
    sw_g   = 4'($urandom_range(0, 15));
    sw_b   = 4'($urandom_range(0, 15));
    sw_td  = 4'($urandom_range(0, 15));
    sw_reg = 4'($urandom_range(0, 15));
  endtask

  // Ends at the sampling point of the GPIOEn (MARK) cycle.
  task automatic start_run();
    swInicio = 1'b0;
    @(negedge clk);
    m_r = sw_r; m_g = sw_g; m_b = sw_b; m_td = sw_td; m_reg = sw_reg;
    swInicio = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rand_sw();
    do_reset();
    total++;
    if (GPIO !== '0) begin
      bad++; $display("FAIL reset_gpio: got %h want 0", GPIO);
    end
    total++;
    if (stb !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes: got %b want 0000", stb);
    end
    @(negedge clk);
    total++;
    if (stb !== 4'b0000) begin
      bad++; $display("FAIL reset_idle_strobes: got %b want 0000", stb);
    end
  endtask

  task automatic test_basic();
    logic [127:0] e;
    do_reset();
    sw_r = 4'b0100; sw_g = 4'b0010; sw_b = 4'b0010; sw_td = 4'b0100; sw_reg = 4'b1000;
    start_run();
    total++;
    if (stb !== 4'b1000) begin
      bad++; $display("FAIL basic_mark: got %b want 1000", stb);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      total++;
      if (stb !== exp_stb(i % 3)) begin
        bad++; $display("FAIL basic_strobe[%0d]: got %b want %b", i, stb, exp_stb(i % 3));
      end
      e = exp_vec(i / 3, i % 3);
      total++;
      if (GPIO !== e) begin
        bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, GPIO, e);
      end
    end
  endtask

  task automatic test_full_frame();
    int n_en, n_r, n_g, n_b;
    logic [127:0] e;
    do_reset();
    rand_sw();
    start_run();
    n_en = 0; n_r = 0; n_g = 0; n_b = 0;
    if (GPIOEn) n_en++;
    rand_sw();  // changes after the start edge must be ignored
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      n_en += int'(GPIOEn); n_r += int'(GPIOEnR); n_g += int'(GPIOEnG); n_b += int'(GPIOEnB);
      total++;
      if (stb !== exp_stb(i % 3)) begin
        bad++; $display("FAIL frame_strobe[%0d]: got %b want %b", i, stb, exp_stb(i % 3));
      end
      e = exp_vec(i / 3, i % 3);
      total++;
      if (GPIO !== e) begin
        bad++; $display("FAIL frame_data[%0d]: got %h want %h", i, GPIO, e);
      end
    end
    e = exp_vec(9999, 2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_en += int'(GPIOEn); n_r += int'(GPIOEnR); n_g += int'(GPIOEnG); n_b += int'(GPIOEnB);
      total++;
      if (stb !== 4'b0000) begin
        bad++; $display("FAIL done_strobe[%0d]: got %b want 0000", i, stb);
      end
      total++;
      if (GPIO !== e) begin
        bad++; $display("FAIL done_hold[%0d]: got %h want %h", i, GPIO, e);
      end
    end
    total++;
    if (n_en != 1 || n_r != 10000 || n_g != 10000 || n_b != 10000) begin
      bad++; $display("FAIL frame_counts: got en=%0d r=%0d g=%0d b=%0d want 1/10000/10000/10000",
                      n_en, n_r, n_g, n_b);
    end
    // Restart from DONE after dropping the start level.
    rand_sw();
    start_run();
    total++;
    if (stb !== 4'b1000) begin
      bad++; $display("FAIL restart_mark: got %b want 1000", stb);
    end
    @(negedge clk);
    e = exp_vec(0, 0);
    total++;
    if (GPIO !== e || stb !== 4'b0100) begin
      bad++; $display("FAIL restart_first: got %h/%b want %h/0100", GPIO, stb, e);
    end
  endtask

  task automatic test_opaque();
    logic [127:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      rand_sw();
      sw_r = 4'b1000; sw_reg = 4'b1000;
      sw_td = (pass == 0) ? 4'b0001 : 4'b1000;
      start_run();
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (i % 3 == 0) begin
          for (int k = 0; k < 4; k++)
            e[32*k +: 32] = (pass == 0) ? 32'd255 : 32'(((i / 3) % 50) * 4 + k);
          total++;
          if (GPIO !== e || !GPIOEnR) begin
            bad++; $display("FAIL opaque%0d_r[%0d]: got %h want %h", pass, i / 3, GPIO, e);
          end
        end
      end
    end
  endtask

  task automatic test_region();
    logic [127:0] e, row99, row100;
    row99 = {4{32'd255}};
`ifdef PROCESSORS_MASK_EN
    row100 = {32'd3, 32'd2, 32'd1, 32'd0};
`else
    row100 = {4{32'd255}};
`endif
    do_reset();
    rand_sw();
    sw_reg = 4'b0001; sw_r = 4'b1000; sw_td = 4'b0001;
    start_run();
    for (int i = 0; i < 5050 * 3; i++) begin
      @(negedge clk);
      e = exp_vec(i / 3, i % 3);
      total++;
      if (GPIO !== e || stb !== exp_stb(i % 3)) begin
        bad++; $display("FAIL region[%0d]: got %h/%b want %h/%b", i, GPIO, stb, e, exp_stb(i % 3));
      end
      if (i == 4950 * 3) begin
        total++;
        if (GPIO !== row99) begin
          bad++; $display("FAIL region_row99: got %h want %h", GPIO, row99);
        end
      end
      if (i == 5000 * 3) begin
        total++;
        if (GPIO !== row100) begin
          bad++; $display("FAIL region_row100: got %h want %h", GPIO, row100);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [127:0] e;
    do_reset();
    rand_sw();
    start_run();
    repeat (1500) @(negedge clk);
    rst = 1'b1;  // swInicio stays high
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (GPIO !== '0 || stb !== 4'b0000) begin
      bad++; $display("FAIL abort_clear: got %h/%b want 0/0000", GPIO, stb);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (stb !== 4'b0000) begin
        bad++; $display("FAIL abort_no_restart[%0d]: got %b want 0000", i, stb);
      end
    end
    rand_sw();
    start_run();
    total++;
    if (stb !== 4'b1000) begin
      bad++; $display("FAIL abort_mark: got %b want 1000", stb);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = exp_vec(i / 3, i % 3);
      total++;
      if (GPIO !== e || stb !== exp_stb(i % 3)) begin
        bad++; $display("FAIL abort_restart[%0d]: got %h/%b want %h/%b", i, GPIO, stb, e, exp_stb(i % 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] e;
    for (int run = 0; run < 4; run++) begin
      do_reset();
      rand_sw();
      start_run();
      rand_sw();
      for (int i = 0; i < 156; i++) begin
        @(negedge clk);
        e = exp_vec(i / 3, i % 3);
        total++;
        if (GPIO !== e || stb !== exp_stb(i % 3)) begin
          bad++; $display("FAIL b2b%0d[%0d]: got %h/%b want %h/%b", run, i, GPIO, stb, e, exp_stb(i % 3));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_frame();
    test_opaque();
    test_region();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
